// File: rtl/mem_access_unit.sv
// ============================================================================
// mem_access_unit : load/store initiator with req/ack handshake and timeout
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_access_unit #(
    parameter logic [31:0] ADDR_HIGH = 32'h0000_2FFF,
    parameter int          TIMEOUT   = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic        i_is_store,
    input  logic [1:0]  i_access_type,
    input  logic        i_sign_read,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_store_data,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_load_data,
    output logic        o_addr_err,
    output logic        o_bus_err,
    output logic        o_bus_req,
    output logic        o_bus_write,
    output logic [31:0] o_bus_addr,
    output logic [3:0]  o_bus_byte_en,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata
);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_REQ  = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;
    localparam logic [1:0] c_S_ERR  = 2'd3;

    localparam logic [1:0] c_AT_WORD = 2'd0;
    localparam logic [1:0] c_AT_HALF = 2'd1;
    localparam logic [1:0] c_AT_BYTE = 2'd2;

    localparam logic [7:0] c_CNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  r_state;
    logic [7:0]  r_cnt;
    logic [1:0]  r_type;
    logic        r_sign;
    logic [1:0]  r_lane;
    logic        r_busy;
    logic        r_done;
    logic        r_addr_err;
    logic        r_bus_err;
    logic        r_bus_req;
    logic        r_bus_write;
    logic [31:0] r_bus_addr;
    logic [3:0]  r_bus_be;
    logic [31:0] r_bus_wdata;
    logic [31:0] r_load_data;

    logic        w_illegal;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [15:0] w_half;
    logic [7:0]  w_byte;
    logic [31:0] w_load_ext;

    always_comb begin
        w_illegal = (i_addr > ADDR_HIGH);
        w_be      = 4'b1111;
        w_wdata   = i_store_data;
        case (i_access_type)
            c_AT_WORD: begin
                w_illegal = w_illegal | (i_addr[1:0] != 2'b00);
            end
            c_AT_HALF: begin
                w_illegal = w_illegal | i_addr[0];
                w_be      = i_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata   = {2{i_store_data[15:0]}};
            end
            c_AT_BYTE: begin
                w_be    = 4'b0001 << i_addr[1:0];
                w_wdata = {4{i_store_data[7:0]}};
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    // Extraction uses the lane/type latched at request time, not the live inputs.
    always_comb begin
        w_half = r_lane[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
        case (r_lane)
            2'd0:    w_byte = i_bus_rdata[7:0];
            2'd1:    w_byte = i_bus_rdata[15:8];
            2'd2:    w_byte = i_bus_rdata[23:16];
            default: w_byte = i_bus_rdata[31:24];
        endcase
        case (r_type)
            c_AT_HALF: w_load_ext = {{16{r_sign & w_half[15]}}, w_half};
            c_AT_BYTE: w_load_ext = {{24{r_sign & w_byte[7]}}, w_byte};
            default:   w_load_ext = i_bus_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_S_IDLE;
            r_cnt       <= 8'd0;
            r_type      <= 2'd0;
            r_sign      <= 1'b0;
            r_lane      <= 2'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_addr_err  <= 1'b0;
            r_bus_err   <= 1'b0;
            r_bus_req   <= 1'b0;
            r_bus_write <= 1'b0;
            r_bus_addr  <= 32'd0;
            r_bus_be    <= 4'd0;
            r_bus_wdata <= 32'd0;
            r_load_data <= 32'd0;
        end else begin
            r_done     <= 1'b0;
            r_addr_err <= 1'b0;
            r_bus_err  <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (i_start) begin
                        if (w_illegal) begin
                            r_state    <= c_S_ERR;
                            r_done     <= 1'b1;
                            r_addr_err <= 1'b1;
                        end else begin
                            r_state     <= c_S_REQ;
                            r_cnt       <= 8'd0;
                            r_busy      <= 1'b1;
                            r_bus_req   <= 1'b1;
                            r_bus_write <= i_is_store;
                            r_bus_addr  <= {i_addr[31:2], 2'b00};
                            r_bus_be    <= w_be;
                            r_bus_wdata <= w_wdata;
                            r_type      <= i_access_type;
                            r_sign      <= i_sign_read;
                            r_lane      <= i_addr[1:0];
                        end
                    end
                end
                c_S_REQ: begin
                    // An ack on the final allowed cycle takes priority over the timeout.
                    if (i_bus_ack) begin
                        r_state   <= c_S_DONE;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_bus_req <= 1'b0;
                        if (!r_bus_write) begin
                            r_load_data <= w_load_ext;
                        end
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_state   <= c_S_ERR;
                        r_done    <= 1'b1;
                        r_bus_err <= 1'b1;
                        r_busy    <= 1'b0;
                        r_bus_req <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_load_data   = r_load_data;
    assign o_addr_err    = r_addr_err;
    assign o_bus_err     = r_bus_err;
    assign o_bus_req     = r_bus_req;
    assign o_bus_write   = r_bus_write;
    assign o_bus_addr    = r_bus_addr;
    assign o_bus_byte_en = r_bus_be;
    assign o_bus_wdata   = r_bus_wdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// tb_mem_access_unit : directed + random checks of mem_access_unit
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

    localparam logic [31:0] ADDR_HIGH = 32'h0000_2FFF;
    localparam int          TIMEOUT   = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic        i_is_store = 1'b0;
    logic [1:0]  i_access_type = 2'd0;
    logic        i_sign_read = 1'b0;
    logic [31:0] i_addr = 32'd0;
    logic [31:0] i_store_data = 32'd0;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_load_data;
    logic        o_addr_err;
    logic        o_bus_err;
    logic        o_bus_req;
    logic        o_bus_write;
    logic [31:0] o_bus_addr;
    logic [3:0]  o_bus_byte_en;
    logic [31:0] o_bus_wdata;
    logic        i_bus_ack = 1'b0;
    logic [31:0] i_bus_rdata = 32'd0;

    int          n_assert = 0;
    int          n_fail = 0;
    logic [31:0] m_load = 32'd0;

    mem_access_unit #(.ADDR_HIGH(ADDR_HIGH), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start       (i_start),
        .i_is_store    (i_is_store),
        .i_access_type (i_access_type),
        .i_sign_read   (i_sign_read),
        .i_addr        (i_addr),
        .i_store_data  (i_store_data),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_load_data   (o_load_data),
        .o_addr_err    (o_addr_err),
        .o_bus_err     (o_bus_err),
        .o_bus_req     (o_bus_req),
        .o_bus_write   (o_bus_write),
        .o_bus_addr    (o_bus_addr),
        .o_bus_byte_en (o_bus_byte_en),
        .o_bus_wdata   (o_bus_wdata),
        .i_bus_ack     (i_bus_ack),
        .i_bus_rdata   (i_bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference extraction: shift the addressed lane down, mask, then widen.
    function automatic logic [31:0] ref_load(input logic [1:0] at, input logic sg,
                                             input logic [1:0] lane, input logic [31:0] w);
        logic [31:0] v;
        case (at)
            2'd1: begin
                v = (w >> (16 * int'(lane[1]))) & 32'h0000_FFFF;
                if (sg && v[15]) v = v | 32'hFFFF_0000;
            end
            2'd2: begin
                v = (w >> (8 * int'(lane))) & 32'h0000_00FF;
                if (sg && v[7]) v = v | 32'hFFFF_FF00;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    task automatic do_access(input logic st, input logic [1:0] at, input logic sg,
                             input logic [31:0] ad, input logic [31:0] sd,
                             input logic [31:0] rd, input int waits);
        logic        ill;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        got;
        ill = (at == 2'd3) || (ad > ADDR_HIGH) ||
              (at == 2'd0 && ad[1:0] != 2'b00) || (at == 2'd1 && ad[0]);
        case (at)
            2'd1:    begin be = ad[1] ? 4'b1100 : 4'b0011; wd = {sd[15:0], sd[15:0]}; end
            2'd2:    begin be = 4'(1 << ad[1:0]); wd = {sd[7:0], sd[7:0], sd[7:0], sd[7:0]}; end
            default: begin be = 4'b1111; wd = sd; end
        endcase
        i_is_store = st; i_access_type = at; i_sign_read = sg;
        i_addr = ad; i_store_data = sd; i_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_start = 1'b0;
        if (ill) begin
            chk("err_done", 32'(o_done), 32'd1);
            chk("err_addr_err", 32'(o_addr_err), 32'd1);
            chk("err_bus_err", 32'(o_bus_err), 32'd0);
            chk("err_bus_req", 32'(o_bus_req), 32'd0);
            chk("err_busy", 32'(o_busy), 32'd0);
            chk("err_load_held", o_load_data, m_load);
            @(negedge clk);
            chk("err_after_done", 32'(o_done), 32'd0);
            chk("err_after_flag", 32'(o_addr_err), 32'd0);
            return;
        end
        got = 1'b0;
        for (int k = 0; k < TIMEOUT; k++) begin
            chk("req_bus_req", 32'(o_bus_req), 32'd1);
            chk("req_busy", 32'(o_busy), 32'd1);
            chk("req_done", 32'(o_done), 32'd0);
            chk("req_write", 32'(o_bus_write), 32'(st));
            chk("req_addr", o_bus_addr, {ad[31:2], 2'b00});
            chk("req_be", 32'(o_bus_byte_en), 32'(be));
            chk("req_wdata", o_bus_wdata, wd);
            i_bus_ack    = (k == waits);
            i_bus_rdata  = (k == waits) ? rd : $urandom;
            i_start      = 1'($urandom);
            i_addr       = $urandom;
            i_store_data = $urandom;
            @(negedge clk);
            if (k == waits) begin
                got = 1'b1;
                break;
            end
        end
        i_bus_ack = 1'b0;
        i_start   = 1'b0;
        if (got && !st) m_load = ref_load(at, sg, ad[1:0], rd);
        chk("end_done", 32'(o_done), 32'd1);
        chk("end_bus_err", 32'(o_bus_err), 32'(!got));
        chk("end_addr_err", 32'(o_addr_err), 32'd0);
        chk("end_bus_req", 32'(o_bus_req), 32'd0);
        chk("end_busy", 32'(o_busy), 32'd0);
        chk("end_load", o_load_data, m_load);
        @(negedge clk);
        chk("idle_done", 32'(o_done), 32'd0);
        chk("idle_busy", 32'(o_busy), 32'd0);
        chk("idle_bus_req", 32'(o_bus_req), 32'd0);
    endtask

    initial begin
        #12;
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_load", o_load_data, 32'd0);
        chk("rst_bus_req", 32'(o_bus_req), 32'd0);
        chk("rst_bus_addr", o_bus_addr, 32'd0);
        chk("rst_be", 32'(o_bus_byte_en), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_access(1'b1, 2'd0, 1'b0, 32'h10,   32'hDEADBEEF, 32'h0,        0);
        do_access(1'b0, 2'd2, 1'b1, 32'h23,   32'h0,        32'h80FF0011, 3);
        chk("byte_sx_value", o_load_data, 32'hFFFF_FF80);
        do_access(1'b0, 2'd2, 1'b0, 32'h23,   32'h0,        32'h80FF0011, 3);
        chk("byte_zx_value", o_load_data, 32'h0000_0080);
        do_access(1'b1, 2'd1, 1'b0, 32'h102,  32'h1234ABCD, 32'h0,        1);
        do_access(1'b0, 2'd0, 1'b0, 32'h6,    32'h0,        32'h0,        0);
        do_access(1'b0, 2'd0, 1'b0, 32'h3000, 32'h0,        32'h0,        0);
        chk("addr_err_load_kept", o_load_data, 32'h0000_0080);
        do_access(1'b0, 2'd0, 1'b0, 32'h40,   32'h0,        32'h11223344, TIMEOUT);
        do_access(1'b0, 2'd0, 1'b0, 32'h44,   32'h0,        32'h55667788, TIMEOUT - 1);
        do_access(1'b0, 2'd1, 1'b1, 32'h2FFE, 32'h0,        32'h8001_7FFF, 2);
        do_access(1'b0, 2'd3, 1'b0, 32'h20,   32'h0,        32'h0,        0);

        // Abandon an access with reset in its second REQ cycle.
        i_is_store = 1'b0; i_access_type = 2'd0; i_addr = 32'h80; i_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_start = 1'b0;
        chk("arst_req_c1", 32'(o_bus_req), 32'd1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_bus_req", 32'(o_bus_req), 32'd0);
        chk("arst_busy", 32'(o_busy), 32'd0);
        chk("arst_done", 32'(o_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_load = 32'd0;
        @(negedge clk);
        chk("arst_no_done", 32'(o_done), 32'd0);
        chk("arst_load_cleared", o_load_data, 32'd0);
        do_access(1'b0, 2'd0, 1'b0, 32'h84, 32'h0, 32'hCAFEF00D, 1);

        for (int i = 0; i < 80; i++) begin
            logic [1:0]  at;
            logic [31:0] ad;
            int          w;
            at = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            ad = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 32'h3003));
            if ($urandom_range(0, 3) != 0) begin
                if (at == 2'd0) ad[1:0] = 2'b00;
                if (at == 2'd1) ad[0] = 1'b0;
            end
            w = ($urandom_range(0, 7) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT + 1)
                                            : $urandom_range(0, 4);
            do_access(1'($urandom), at, 1'($urandom), ad, $urandom, $urandom, w);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
